multi_cycle_control_unit: RTL

- FSM sequencer for the multi-cycle RV32I datapath: walks each instruction through IF/ID/EX/MEM/WB and drives per-cycle datapath enables and muxes.
- Replaces the single-cycle opcode decoder. Sits between the IR opcode field and the shared datapath: one ALU, one unified memory with ready handshake, register file and PC.
- Memory access stalls on mem_ready; the PC is written only in the final cycle of each instruction.

---
 rtl/multi_cycle_control_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/MEM/WB and drives datapath enables.
// Define MC_PERF_CNT_EN to add the cycle/instruction performance counters.
module multi_cycle_control_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 alu_bcond,
  input  logic                 mem_ready,
  output logic                 ir_write,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 pc_to_reg,
  output logic                 pc_write,
  output logic [1:0]           pc_source,
  output logic                 is_ecall,
  output logic                 instr_done,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic is_load, is_store, is_arith, is_arith_imm, is_jal, is_jalr, is_branch;
  assign is_load      = (opcode == OP_LOAD);
  assign is_store     = (opcode == OP_STORE);
  assign is_arith     = (opcode == OP_ARITH);
  assign is_arith_imm = (opcode == OP_ARITH_IMM);
  assign is_jal       = (opcode == OP_JAL);
  assign is_jalr      = (opcode == OP_JALR);
  assign is_branch    = (opcode == OP_BRANCH);

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= S_IF;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = S_IF;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'd0;
    is_ecall   = 1'b0;
    instr_done = 1'b0;
    state      = 3'd0;

    case (state_reg)
      S_IF: begin
        mem_read   = 1'b1;
        ir_write   = mem_ready;
        state_next = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        is_ecall   = (opcode == OP_ECALL);
        state_next = S_EX;
      end
      S_EX: begin
        alu_src = is_load | is_store | is_arith_imm | is_jalr;
        if (is_load || is_store) begin
          state_next = S_MEM;
        end else if (is_arith || is_arith_imm || is_jal || is_jalr) begin
          state_next = S_WB;
        end else begin
          // Branches resolve here; ECALL and unknown opcodes retire as NOPs.
          pc_write   = 1'b1;
          pc_source  = (is_branch && alu_bcond) ? 2'd1 : 2'd0;
          instr_done = 1'b1;
          state_next = S_IF;
        end
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (is_load) begin
          mem_read   = 1'b1;
          state_next = mem_ready ? S_WB : S_MEM;
        end else if (is_store) begin
          mem_write  = 1'b1;
          pc_write   = mem_ready;
          instr_done = mem_ready;
          state_next = mem_ready ? S_IF : S_MEM;
        end else begin
          state_next = S_IF;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        mem_to_reg = is_load;
        pc_to_reg  = is_jal | is_jalr;
        pc_source  = is_jalr ? 2'd2 : (is_jal ? 2'd1 : 2'd0);
        state_next = S_IF;
      end
      default: state_next = S_IF;
    endcase

    state = state_reg;

    // Reset forces every output low without waiting for a clock edge.
    if (!reset) begin
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      pc_to_reg  = 1'b0;
      pc_write   = 1'b0;
      pc_source  = 2'd0;
      is_ecall   = 1'b0;
      instr_done = 1'b0;
      state      = 3'd0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_count_reg, instr_count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count_reg <= '0;
      instr_count_reg <= '0;
    end else begin
      cycle_count_reg <= cycle_count_reg + 1'b1;
      if (instr_done) instr_count_reg <= instr_count_reg + 1'b1;
    end
  end

  assign cycle_count = reset ? cycle_count_reg : '0;
  assign instr_count = reset ? instr_count_reg : '0;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule
